// File: rtl/mini_alu_pkg.sv
// Shared opcode, FSM state and instruction-field definitions for the mini ALU core.
package mini_alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned FIELD_N = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_STO  = 4'd3,
    OP_BLE  = 4'd4,
    OP_JMP  = 4'd5,
    OP_LED  = 4'd6,
    OP_SMUL = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WRLO = 2'd2,
    ST_WRHI = 2'd3
  } state_e;

  function automatic int unsigned instr_width(input int unsigned addr_w);
    return OP_W + FIELD_N * addr_w;
  endfunction

endpackage

// File: rtl/signed_mul_seq.sv
// Radix-2 Booth sequential signed multiplier: one step per cycle, DATA_W steps per product.
module signed_mul_seq #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W:0]   acc_q, acc_d, m_ext, sum;
  logic [DATA_W-1:0] q_q, q_d, m_q, m_d;
  logic              qm1_q, qm1_d, run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Accumulator carries one guard bit so adding/subtracting -2**(DATA_W-1) cannot overflow.
  always_comb begin
    m_ext = {m_q[DATA_W-1], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase

    acc_d = acc_q;
    q_d   = q_q;
    m_d   = m_q;
    qm1_d = qm1_q;
    run_d = run_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = '0;
      q_d   = b;
      m_d   = a;
      qm1_d = 1'b0;
      run_d = 1'b1;
      cnt_d = '0;
    end else if (run_q) begin
      acc_d = {sum[DATA_W], sum[DATA_W:1]};
      q_d   = {sum[0], q_q[DATA_W-1:1]};
      qm1_d = q_q[0];
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      q_q   <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      q_q   <= q_d;
      m_q   <= m_d;
      qm1_q <= qm1_d;
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  // done marks the final step; product is valid from the following cycle until the next start.
  assign done    = run_q && (cnt_q == LAST);
  assign product = {acc_q[DATA_W-1:0], q_q};

endmodule

// File: rtl/mini_alu_gen.sv
// Mini ALU core: fetch from external async ROM, single-cycle ALU/branch ops,
// multi-cycle signed multiply writing a double-width result to dst and dst+1.
module mini_alu_gen
  import mini_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IP_W   = 16,
  parameter int unsigned LED_W  = 8
) (
  input  logic                            Clock,
  input  logic                            Reset,
  output logic [IP_W-1:0]                 oIP,
  input  logic [OP_W+FIELD_N*ADDR_W-1:0]  iInstruction,
  output logic [LED_W-1:0]                oLed,
  output logic                            oBusy,
  output logic                            oOverflow
);

  localparam int unsigned IW       = instr_width(ADDR_W);
  localparam int unsigned RF_DEPTH = 2 ** ADDR_W;
  localparam logic [IW-1:0] IR_NOP = '0;

  logic [IW-1:0]     ir_q, ir_d;
  logic [IP_W-1:0]   ip_q, ip_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              ovf_q, ovf_d, busy_q, busy_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mdst_q, mdst_d;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] dst, src1, src0;
  logic [DATA_W-1:0] rf [RF_DEPTH];
  logic [DATA_W-1:0] rs1, rs0, sum, diff;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] product;

  assign {op, dst, src1, src0} = ir_q;
  assign rs1  = rf[src1];
  assign rs0  = rf[src0];
  assign sum  = rs1 + rs0;
  assign diff = rs1 - rs0;

  signed_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (Clock),
    .rst_n   (Reset),
    .start   (mul_start),
    .a       (rs1),
    .b       (rs0),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    ir_d      = iInstruction;
    ip_d      = ip_q + IP_W'(1);
    led_d     = led_q;
    ovf_d     = ovf_q;
    state_d   = state_q;
    mdst_d    = mdst_q;
    rf_we     = 1'b0;
    rf_waddr  = dst;
    rf_wdata  = '0;
    mul_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        case (op)
          OP_ADD: begin
            rf_we    = 1'b1;
            rf_wdata = sum;
            if (rs1[DATA_W-1] == rs0[DATA_W-1] && sum[DATA_W-1] != rs1[DATA_W-1]) ovf_d = 1'b1;
          end
          OP_SUB: begin
            rf_we    = 1'b1;
            rf_wdata = diff;
            if (rs1[DATA_W-1] != rs0[DATA_W-1] && diff[DATA_W-1] != rs1[DATA_W-1]) ovf_d = 1'b1;
          end
          OP_STO: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'({src1, src0});
          end
          OP_BLE, OP_JMP: begin
            if (op == OP_JMP || rs1 <= rs0) begin
              ip_d = IP_W'(dst);
              ir_d = IR_NOP;
            end
          end
          OP_LED:  led_d = rs1[LED_W-1:0];
          OP_SMUL: begin
            mul_start = 1'b1;
            mdst_d    = dst;
            state_d   = ST_MUL;
          end
          default: ;
        endcase
      end
      // Fetch is frozen while the multiply occupies the core; the instruction
      // already in IR executes once the FSM returns to IDLE.
      ST_MUL: begin
        ir_d = ir_q;
        ip_d = ip_q;
        if (mul_done) state_d = ST_WRLO;
      end
      ST_WRLO: begin
        ir_d     = ir_q;
        ip_d     = ip_q;
        rf_we    = 1'b1;
        rf_waddr = mdst_q;
        rf_wdata = product[DATA_W-1:0];
        state_d  = ST_WRHI;
      end
      ST_WRHI: begin
        ir_d     = ir_q;
        ip_d     = ip_q;
        rf_we    = 1'b1;
        rf_waddr = mdst_q + ADDR_W'(1);
        rf_wdata = product[2*DATA_W-1:DATA_W];
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ir_q    <= IR_NOP;
      ip_q    <= '0;
      led_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= ST_IDLE;
      mdst_q  <= '0;
    end else begin
      ir_q    <= ir_d;
      ip_q    <= ip_d;
      led_q   <= led_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      state_q <= state_d;
      mdst_q  <= mdst_d;
    end
  end

  // Register file keeps its contents across reset.
  always_ff @(posedge Clock) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign oIP       = ip_q;
  assign oLed      = led_q;
  assign oBusy     = busy_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_mini_alu_gen.sv
// Scoreboard bench for mini_alu_gen: directed programs in a ROM model, LED and busy-pulse monitors.
module tb_mini_alu_gen;
  import mini_alu_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned IPW = 16;
  localparam int unsigned LW = 16;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic [IPW-1:0] oIP;
  logic [27:0]    iInstruction;
  logic [LW-1:0]  oLed;
  logic           oBusy, oOverflow;

  logic [27:0] rom [256];
  assign iInstruction = rom[oIP[7:0]];

  mini_alu_gen #(.DATA_W(DW), .ADDR_W(AW), .IP_W(IPW), .LED_W(LW)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oIP          (oIP),
    .iInstruction (iInstruction),
    .oLed         (oLed),
    .oBusy        (oBusy),
    .oOverflow    (oOverflow)
  );

  always #5 Clock = ~Clock;

  int cyc;
  always @(posedge Clock or negedge Reset)
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct { string name; logic [15:0] led; logic ovf; int cyc; } led_exp_t;
  typedef struct { string name; int len; logic [15:0] ip; } busy_exp_t;
  led_exp_t  led_sb[$];
  busy_exp_t busy_sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [27:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {OP_STO, d, imm};
  endfunction

  task automatic exp_led(input string n, input logic [15:0] v, input logic o, input int c);
    led_sb.push_back('{name: n, led: v, ovf: o, cyc: c});
  endtask

  task automatic exp_busy(input string n, input int len, input logic [15:0] ip);
    busy_sb.push_back('{name: n, len: len, ip: ip});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    check("rst_ip", 32'(oIP), 0);
    check("rst_led", 32'(oLed), 0);
    check("rst_ovf", 32'(oOverflow), 0);
    check("rst_busy", 32'(oBusy), 0);
  endtask

  task automatic release_reset();
    @(negedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic wait_drain(input string n, input int budget);
    for (int i = 0; i < budget && (led_sb.size() + busy_sb.size()) != 0; i++) @(negedge Clock);
    repeat (5) @(negedge Clock);
    check({n, "_drain"}, 32'(led_sb.size() + busy_sb.size()), 0);
  endtask

  // Monitor: pops an expectation whenever oLed changes or a busy pulse ends.
  initial begin
    logic [15:0] prev_led;
    logic        in_busy, ip_ok;
    int          blen;
    logic [15:0] bip;
    led_exp_t    e;
    busy_exp_t   b;
    prev_led = '0;
    in_busy  = 1'b0;
    ip_ok    = 1'b1;
    blen     = 0;
    bip      = '0;
    forever begin
      @(negedge Clock);
      if (Reset !== 1'b1) begin
        prev_led = '0;
        in_busy  = 1'b0;
      end else begin
        if (oLed !== prev_led) begin
          prev_led = oLed;
          if (led_sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_led: oLed=%h with no pending expectation", oLed);
          end else begin
            e = led_sb.pop_front();
            check({e.name, "_led"}, 32'(oLed), 32'(e.led));
            check({e.name, "_ovf"}, 32'(oOverflow), 32'(e.ovf));
            if (e.cyc >= 0) check({e.name, "_cyc"}, cyc, e.cyc);
          end
        end
        if (oBusy && !in_busy) begin
          in_busy = 1'b1;
          blen    = 1;
          bip     = oIP;
          ip_ok   = 1'b1;
        end else if (oBusy) begin
          blen++;
          if (oIP !== bip) ip_ok = 1'b0;
        end else if (in_busy) begin
          in_busy = 1'b0;
          if (busy_sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_busy: pulse of %0d cycles with no pending expectation", blen);
          end else begin
            b = busy_sb.pop_front();
            check({b.name, "_len"}, blen, b.len);
            check({b.name, "_ip"}, 32'(bip), 32'(b.ip));
            check({b.name, "_ip_frozen"}, 32'(ip_ok), 1);
          end
        end
      end
    end
  end

  initial begin
    logic found;

    // A: add, sticky overflow, undefined opcode
    clear_rom();
    do_reset();
    rom[0]  = sto(8'd1, 16'h0005);
    rom[1]  = sto(8'd2, 16'h0003);
    rom[2]  = ins(OP_ADD, 8'd3, 8'd1, 8'd2);
    rom[3]  = ins(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[4]  = sto(8'd1, 16'h7FFF);
    rom[5]  = sto(8'd2, 16'h0001);
    rom[6]  = ins(OP_ADD, 8'd3, 8'd1, 8'd2);
    rom[7]  = ins(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[8]  = ins(OP_SUB, 8'd4, 8'd2, 8'd2);
    rom[9]  = ins(OP_ADD, 8'd4, 8'd4, 8'd2);
    rom[10] = ins(OP_LED, 8'd0, 8'd4, 8'd0);
    rom[11] = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[12] = ins(4'hA, 8'd4, 8'd1, 8'd2);
    rom[13] = ins(OP_LED, 8'd0, 8'd4, 8'd0);
    rom[14] = ins(OP_JMP, 8'd14, 8'd0, 8'd0);
    exp_led("A_add", 16'h0008, 1'b0, 5);
    exp_led("A_ovf_add", 16'h8000, 1'b1, -1);
    exp_led("A_sticky", 16'h0001, 1'b1, -1);
    exp_led("A_r1", 16'h7FFF, 1'b1, -1);
    exp_led("A_op_a", 16'h0001, 1'b1, -1);
    release_reset();
    wait_drain("A", 200);

    // B: SMUL timing, dst+1 forwarding, dst=0xFF wrap, SUB overflow after reset
    do_reset();
    clear_rom();
    rom[0]  = sto(8'd5, 16'hFFFD);
    rom[1]  = sto(8'd6, 16'h0007);
    rom[2]  = ins(OP_SMUL, 8'd4, 8'd5, 8'd6);
    rom[3]  = ins(OP_LED, 8'd0, 8'd4, 8'd0);
    rom[4]  = ins(OP_LED, 8'd0, 8'd5, 8'd0);
    rom[5]  = ins(OP_SMUL, 8'hFF, 8'd5, 8'd6);
    rom[6]  = ins(OP_LED, 8'd0, 8'hFF, 8'd0);
    rom[7]  = ins(OP_LED, 8'd0, 8'd0, 8'd0);
    rom[8]  = sto(8'd7, 16'h8000);
    rom[9]  = sto(8'd8, 16'h0001);
    rom[10] = ins(OP_SUB, 8'd9, 8'd7, 8'd8);
    rom[11] = ins(OP_LED, 8'd0, 8'd9, 8'd0);
    rom[12] = ins(OP_JMP, 8'd12, 8'd0, 8'd0);
    exp_busy("B_mul1", 18, 16'd4);
    exp_busy("B_mul2", 18, 16'd7);
    exp_led("B_lo", 16'hFFEB, 1'b0, 23);
    exp_led("B_hi", 16'hFFFF, 1'b0, 24);
    exp_led("B_wrap_lo", 16'hFFF9, 1'b0, -1);
    exp_led("B_wrap_hi", 16'hFFFF, 1'b0, -1);
    exp_led("B_sub_ovf", 16'h7FFF, 1'b1, -1);
    release_reset();
    wait_drain("B", 300);

    // C: BLE loop, four iterations, one bubble per taken branch
    do_reset();
    clear_rom();
    rom[0]  = sto(8'd1, 16'h0000);
    rom[1]  = sto(8'd2, 16'h0001);
    rom[2]  = sto(8'd3, 16'h0003);
    rom[3]  = ins(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[4]  = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[5]  = ins(OP_ADD, 8'd1, 8'd1, 8'd2);
    rom[6]  = ins(OP_BLE, 8'd4, 8'd1, 8'd3);
    rom[7]  = sto(8'd3, 16'h0000);
    rom[8]  = ins(OP_LED, 8'd0, 8'd1, 8'd0);
    rom[9]  = ins(OP_LED, 8'd0, 8'd3, 8'd0);
    rom[10] = ins(OP_JMP, 8'd10, 8'd0, 8'd0);
    exp_led("C_pre", 16'h0003, 1'b0, 5);
    exp_led("C_it0", 16'h0000, 1'b0, 6);
    exp_led("C_it1", 16'h0001, 1'b0, 10);
    exp_led("C_it2", 16'h0002, 1'b0, 14);
    exp_led("C_it3", 16'h0003, 1'b0, 18);
    exp_led("C_exit", 16'h0004, 1'b0, 22);
    exp_led("C_fallthru", 16'h0000, 1'b0, 23);
    release_reset();
    wait_drain("C", 200);

    // D: reset in MUL cycle 5 aborts without touching dst/dst+1
    do_reset();
    clear_rom();
    rom[0] = sto(8'd4, 16'h1234);
    rom[1] = sto(8'd5, 16'h5678);
    rom[2] = sto(8'd6, 16'h0002);
    rom[3] = ins(OP_SMUL, 8'd4, 8'd6, 8'd6);
    rom[4] = ins(OP_JMP, 8'd4, 8'd0, 8'd0);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge Clock);
      if (oBusy === 1'b1) found = 1'b1;
    end
    check("D_busy_seen", 32'(found), 1);
    repeat (4) @(negedge Clock);
    #1 Reset = 1'b0;
    #1;
    check("D_abort_busy", 32'(oBusy), 0);
    check("D_abort_ip", 32'(oIP), 0);
    clear_rom();
    rom[0] = ins(OP_LED, 8'd0, 8'd4, 8'd0);
    rom[1] = ins(OP_LED, 8'd0, 8'd5, 8'd0);
    rom[2] = ins(OP_JMP, 8'd2, 8'd0, 8'd0);
    repeat (2) @(negedge Clock);
    exp_led("D_dst", 16'h1234, 1'b0, 2);
    exp_led("D_dst1", 16'h5678, 1'b0, 3);
    release_reset();
    wait_drain("D", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
